dtc_rdout_sched: RTL and testbench

Readout scheduler for the per-channel DTC event RAMs. Each DTC channel's RAM manager raises a ram-full flag once a write completes. This block picks one full, enabled channel at a time in round-robin order and hands it to the single event-builder reader. It holds that channel's read-confirm for the whole read, then releases it so the channel's manager returns its RAM to the writer. A timeout forces a RAM clear if the reader stalls.

---
 rtl/dtc_rdout_pkg.sv | 10 +
 rtl/dtc_rr_pick.sv | 25 ++
 rtl/dtc_rdout_sched.sv | 117 +++++++++++
 tb/tb_dtc_rdout_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_rdout_pkg.sv
// dtc_rdout_pkg: state encoding and constants shared by the DTC readout scheduler.
package dtc_rdout_pkg;
    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        READ    = 4'b0100,
        RELEASE = 4'b1000
    } state_t;
    localparam int RELEASE_GUARD = 8;
endpackage

// File: rtl/dtc_rr_pick.sv
// dtc_rr_pick: combinational round-robin picker; the search starts one past ptr.
module dtc_rr_pick #(
    parameter int NCH = 40,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] pending,
    input  logic [CHW-1:0] ptr,
    output logic           found,
    output logic [CHW-1:0] idx
);
    logic [CHW-1:0] cand;
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest candidate back so the nearest set bit wins.
        for (int i = NCH; i >= 1; i--) begin
            cand = CHW'((int'(ptr) + i) % NCH);
            if (pending[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/dtc_rdout_sched.sv
// dtc_rdout_sched: grants one full, enabled DTC channel RAM at a time to the event-builder
// reader in round-robin order, holding read_confirm for the read and clearing on stall.
module dtc_rdout_sched
    import dtc_rdout_pkg::*;
#(
    parameter int NCH  = 40,
    parameter int TO_W = 16,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  ch_en,
    input  logic [NCH-1:0]  ram_flag,
    input  logic            rd_ack,
    input  logic            rd_done,
    input  logic [TO_W-1:0] to_limit,
    output logic            rd_req,
    output logic [CHW-1:0]  rd_ch,
    output logic [NCH-1:0]  read_confirm,
    output logic [NCH-1:0]  ram_clr,
    output logic            to_err,
    output logic            busy
);
    state_t          state, state_nxt;
    logic [CHW-1:0]  ptr, ptr_nxt, rd_ch_nxt, pick_idx;
    logic [TO_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic            pick_found, flag_cur, timeout, guard_done;
    logic            done_seen, done_seen_nxt, tmo;

    dtc_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
        .pending (ram_flag & ch_en),
        .ptr     (ptr),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // cnt holds cycles already spent in REQ/READ, so the pulse lands to_limit cycles after REQ entry.
    assign flag_cur   = ram_flag[rd_ch];
    assign cnt_inc    = cnt + TO_W'(1);
    assign timeout    = (to_limit != '0) && (cnt_inc == to_limit);
    assign guard_done = cnt == TO_W'(RELEASE_GUARD - 1);

    always_comb begin
        state_nxt     = state;
        rd_ch_nxt     = rd_ch;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt_inc;
        done_seen_nxt = 1'b0;
        tmo           = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pick_found) begin
                    state_nxt = REQ;
                    rd_ch_nxt = pick_idx;
                end
            end
            REQ: begin
                if (!flag_cur) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else if (rd_ack && (rd_done || !timeout)) begin
                    state_nxt     = READ;
                    done_seen_nxt = rd_done;
                end else if (timeout) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                    tmo       = 1'b1;
                end
            end
            READ: begin
                // A done that arrived with the ack still ends the read after one cycle.
                if (done_seen || rd_done || !flag_cur) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else if (timeout) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                    tmo       = 1'b1;
                end
            end
            RELEASE: begin
                if (!flag_cur || guard_done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = rd_ch;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= CHW'(NCH - 1);
            cnt          <= '0;
            rd_ch        <= '0;
            done_seen    <= 1'b0;
            rd_req       <= 1'b0;
            busy         <= 1'b0;
            read_confirm <= '0;
            ram_clr      <= '0;
            to_err       <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            cnt          <= cnt_nxt;
            rd_ch        <= rd_ch_nxt;
            done_seen    <= done_seen_nxt;
            rd_req       <= state_nxt == REQ;
            busy         <= state_nxt != IDLE;
            read_confirm <= (state_nxt == READ) ? NCH'(1) << rd_ch_nxt : '0;
            ram_clr      <= tmo ? NCH'(1) << rd_ch : '0;
            to_err       <= tmo;
        end
    end
endmodule

// File: tb/tb_dtc_rdout_sched.sv
// tb_dtc_rdout_sched: directed and randomized checks of dtc_rdout_sched against a
// round-robin service-order model, a scripted reader and a channel-manager model.
module tb_dtc_rdout_sched;
    localparam int NCH  = 40;
    localparam int TO_W = 16;
    localparam int CHW  = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  ch_en = '1;
    logic [NCH-1:0]  ram_flag = '0;
    logic            rd_ack = 1'b0;
    logic            rd_done = 1'b0;
    logic [TO_W-1:0] to_limit = '0;
    logic            rd_req, to_err, busy;
    logic [CHW-1:0]  rd_ch;
    logic [NCH-1:0]  read_confirm, ram_clr;
    int checks = 0;
    int errors = 0;
    int mptr = NCH - 1;

    dtc_rdout_sched #(.NCH(NCH), .TO_W(TO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ch_en        (ch_en),
        .ram_flag     (ram_flag),
        .rd_ack       (rd_ack),
        .rd_done      (rd_done),
        .to_limit     (to_limit),
        .rd_req       (rd_req),
        .rd_ch        (rd_ch),
        .read_confirm (read_confirm),
        .ram_clr      (ram_clr),
        .to_err       (to_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running after 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH-1:0] onehot(input int ch);
        logic [NCH-1:0] v;
        v = '0;
        v[ch[CHW-1:0]] = 1'b1;
        return v;
    endfunction

    // Service order rule: first pending channel strictly after the last served one, wrapping.
    function automatic int rr_next(input logic [NCH-1:0] p, input int last);
        int c;
        for (int i = 1; i <= NCH; i++) begin
            c = (last + i) % NCH;
            if (p[c[CHW-1:0]]) return c;
        end
        return -1;
    endfunction

    // Channel manager: its registered confirm makes the flag drop 3 cycles after confirm falls.
    task automatic finish_release(input int ch);
        repeat (3) tick();
        ram_flag[ch[CHW-1:0]] = 1'b0;
        tick();
    endtask

    task automatic serve(input int ch, input int ack_dly, input int done_dly);
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_ch !== CHW'(ch)) begin
            errors++;
            $display("FAIL grant: rd_req=%0b rd_ch=%0d, expected rd_req=1 rd_ch=%0d", rd_req, rd_ch, ch);
        end
        for (int i = 0; i < ack_dly; i++) begin
            rd_done = (i == 0);
            tick();
        end
        rd_done = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || read_confirm !== '0) begin
            errors++;
            $display("FAIL req_hold ch%0d: rd_req=%0b read_confirm=%h, expected 1 and 0", ch, rd_req, read_confirm);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || read_confirm !== onehot(ch)) begin
            errors++;
            $display("FAIL confirm ch%0d: rd_req=%0b read_confirm=%h, expected 0 and %h", ch, rd_req, read_confirm, onehot(ch));
        end
        repeat (done_dly) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++;
        if (read_confirm !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL confirm_drop ch%0d: read_confirm=%h busy=%0b, expected 0 and 1", ch, read_confirm, busy);
        end
        finish_release(ch);
        checks++;
        if (busy !== 1'b0 || to_err !== 1'b0 || ram_clr !== '0) begin
            errors++;
            $display("FAIL release_done ch%0d: busy=%0b to_err=%0b ram_clr=%h, expected all 0", ch, busy, to_err, ram_clr);
        end
        mptr = ch;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ram_flag = onehot(3);
        repeat (3) tick();
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b0 || rd_ch !== '0 || read_confirm !== '0 || ram_clr !== '0 || to_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_req=%0b busy=%0b rd_ch=%0d read_confirm=%h ram_clr=%h to_err=%0b, expected all 0",
                     rd_req, busy, rd_ch, read_confirm, ram_clr, to_err);
        end
        ram_flag = '0;
        reset = 1'b0;
        mptr = NCH - 1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b, expected 0", busy);
        end
    endtask

    task automatic test_order();
        ram_flag = onehot(0) | onehot(5) | onehot(39);
        serve(0, 0, 1);
        serve(5, 1, 0);
        serve(39, 0, 0);
        ram_flag = onehot(5) | onehot(0);
        serve(0, 2, 2);
        serve(5, 0, 3);
    endtask

    task automatic test_single();
        ram_flag = onehot(3);
        serve(3, 0, 2);
    endtask

    task automatic test_enable();
        int seen;
        seen = 0;
        ch_en = ~onehot(7);
        ram_flag = onehot(7);
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || rd_req !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL disabled_grant: %0d cycles busy on disabled channel 7, expected 0", seen);
        end
        ch_en[7] = 1'b1;
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_ch !== CHW'(7)) begin
            errors++;
            $display("FAIL enable_grant: rd_req=%0b rd_ch=%0d, expected 1 and 7", rd_req, rd_ch);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        ch_en[7] = 1'b0;
        repeat (3) tick();
        checks++;
        if (read_confirm !== onehot(7)) begin
            errors++;
            $display("FAIL enable_drop: read_confirm=%h, expected %h", read_confirm, onehot(7));
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        finish_release(7);
        checks++;
        if (busy !== 1'b0 || read_confirm !== '0) begin
            errors++;
            $display("FAIL enable_end: busy=%0b read_confirm=%h, expected 0 and 0", busy, read_confirm);
        end
        mptr = 7;
        ch_en = '1;
    endtask

    task automatic test_guard();
        ram_flag = onehot(9);
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        repeat (7) tick();
        checks++;
        if (busy !== 1'b1 || read_confirm !== '0) begin
            errors++;
            $display("FAIL guard_hold: busy=%0b read_confirm=%h, expected 1 and 0", busy, read_confirm);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL guard_expire: busy=%0b, expected 0", busy);
        end
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_ch !== CHW'(9)) begin
            errors++;
            $display("FAIL guard_regrant: rd_req=%0b rd_ch=%0d, expected 1 and 9", rd_req, rd_ch);
        end
        ram_flag = '0;
        tick();
        checks++;
        if (rd_req !== 1'b0 || busy !== 1'b1 || to_err !== 1'b0) begin
            errors++;
            $display("FAIL flag_drop: rd_req=%0b busy=%0b to_err=%0b, expected 0 1 0", rd_req, busy, to_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || to_err !== 1'b0 || ram_clr !== '0) begin
            errors++;
            $display("FAIL flag_drop_idle: busy=%0b to_err=%0b ram_clr=%h, expected all 0", busy, to_err, ram_clr);
        end
        mptr = 9;
    endtask

    task automatic test_timeout();
        int lim, ack, c, early;
        to_limit = TO_W'(100);
        ram_flag = onehot(20);
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        early = 0;
        for (int i = 1; i < 100; i++) begin
            if (to_err !== 1'b0 || ram_clr !== '0 || read_confirm !== onehot(20)) early++;
            tick();
        end
        checks++;
        if (early != 0 || to_err !== 1'b1 || ram_clr !== onehot(20) || read_confirm !== '0) begin
            errors++;
            $display("FAIL timeout_100: early=%0d to_err=%0b ram_clr=%h read_confirm=%h, expected 0 1 %h 0",
                     early, to_err, ram_clr, read_confirm, onehot(20));
        end
        ram_flag = '0;
        tick();
        checks++;
        if (to_err !== 1'b0 || ram_clr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_len: to_err=%0b ram_clr=%h busy=%0b, expected all 0", to_err, ram_clr, busy);
        end
        mptr = 20;
        for (int r = 0; r < 3; r++) begin
            lim = $urandom_range(3, 30);
            ack = $urandom_range(0, lim - 1);
            c = $urandom_range(0, NCH - 1);
            early = 0;
            to_limit = TO_W'(lim);
            ram_flag = onehot(c);
            for (int i = 0; i < lim; i++) begin
                tick();
                if (i > 0 && (to_err !== 1'b0 || ram_clr !== '0)) early++;
                rd_ack = (i == ack);
            end
            tick();
            rd_ack = 1'b0;
            checks++;
            if (early != 0 || to_err !== 1'b1 || ram_clr !== onehot(c)) begin
                errors++;
                $display("FAIL timeout_rand lim=%0d ch=%0d: early=%0d to_err=%0b ram_clr=%h, expected 0 1 %h",
                         lim, c, early, to_err, ram_clr, onehot(c));
            end
            ram_flag = '0;
            tick();
            mptr = c;
        end
        to_limit = '0;
        ram_flag = onehot(21);
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        early = 0;
        repeat (300) begin
            tick();
            if (to_err !== 1'b0 || ram_clr !== '0 || read_confirm !== onehot(21)) early++;
        end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        finish_release(21);
        checks++;
        if (early != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_disabled: %0d bad cycles, busy=%0b, expected 0 and 0", early, busy);
        end
        mptr = 21;
    endtask

    task automatic test_back_to_back();
        ram_flag = onehot(33);
        tick();
        rd_ack = 1'b1;
        rd_done = 1'b1;
        tick();
        rd_ack = 1'b0;
        rd_done = 1'b0;
        checks++;
        if (read_confirm !== onehot(33)) begin
            errors++;
            $display("FAIL ack_done_read: read_confirm=%h, expected %h", read_confirm, onehot(33));
        end
        tick();
        checks++;
        if (read_confirm !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_done_release: read_confirm=%h busy=%0b, expected 0 and 1", read_confirm, busy);
        end
        finish_release(33);
        mptr = 33;
        to_limit = TO_W'(10);
        ram_flag = onehot(34);
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        repeat (8) tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++;
        if (to_err !== 1'b0 || ram_clr !== '0 || read_confirm !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_vs_timeout: to_err=%0b ram_clr=%h read_confirm=%h busy=%0b, expected 0 0 0 1",
                     to_err, ram_clr, read_confirm, busy);
        end
        finish_release(34);
        checks++;
        if (to_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_timeout_end: to_err=%0b busy=%0b, expected 0 and 0", to_err, busy);
        end
        mptr = 34;
        to_limit = '0;
    endtask

    task automatic test_async_reset();
        ram_flag = onehot(5);
        serve(5, 0, 0);
        ram_flag = onehot(12);
        tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        ram_flag[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (read_confirm !== '0 || rd_req !== 1'b0 || busy !== 1'b0 || to_err !== 1'b0 || ram_clr !== '0) begin
            errors++;
            $display("FAIL async_reset: read_confirm=%h rd_req=%0b busy=%0b to_err=%0b ram_clr=%h, expected all 0",
                     read_confirm, rd_req, busy, to_err, ram_clr);
        end
        tick();
        reset = 1'b0;
        mptr = NCH - 1;
        serve(0, 1, 1);
        serve(12, 0, 0);
    endtask

    task automatic test_rr_random();
        int c, exp;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 3; k++) begin
                c = $urandom_range(0, NCH - 1);
                if ($urandom_range(0, 1) == 1) ram_flag[c[CHW-1:0]] = 1'b1;
            end
            ch_en = '1;
            c = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 3) == 0) ch_en[c[CHW-1:0]] = 1'b0;
            if ((ram_flag & ch_en) == '0) begin
                ch_en = '1;
                c = n % NCH;
                ram_flag[c[CHW-1:0]] = 1'b1;
            end
            exp = rr_next(ram_flag & ch_en, mptr);
            serve(exp, $urandom_range(0, 3), $urandom_range(0, 4));
        end
        ch_en = '1;
        for (int n = 0; n < NCH && ram_flag != '0; n++) serve(rr_next(ram_flag, mptr), 0, 0);
    endtask

    initial begin
        test_reset();
        test_order();
        test_single();
        test_enable();
        test_guard();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_rr_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
